// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, write-port grant encoding and the buffered-result record
// used by the writeback arbiter and its holding FIFO.
package defs;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MC   = 2'd2
  } grant_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_hold_fifo.sv
// Small synchronous FIFO buffering multi-cycle results ({rd, data}) until
// they win the register-file write port.
module wb_hold_fifo
  import defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  wb_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered
// multi-cycle results drain in idle slots or by a forced one-cycle stall.
module wb_port_arbiter
  import defs::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_reg_write_en,
  input  logic                  wb_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_data_memory,
  input  logic [XLEN-1:0]       wb_alu_result,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd_addr,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  logic                  pipe_req;
  logic [XLEN-1:0]       pipe_wdata;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  wb_entry_t             head, push_entry;
  grant_e                grant;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  assign pipe_req   = wb_reg_write_en && (wb_rd_addr != '0);
  assign pipe_wdata = wb_mem_to_reg ? wb_data_memory : wb_alu_result;

  // Ready is held high while in reset; x0 handshakes complete but are dropped.
  assign mc_ready        = !rst_n || !fifo_full;
  assign push            = mc_valid && mc_ready && (mc_rd_addr != '0);
  assign push_entry.rd   = mc_rd_addr;
  assign push_entry.data = mc_data;
  assign pop             = (grant == GNT_MC);

  wb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  always_comb begin
    grant     = GNT_NONE;
    stall_req = 1'b0;
    if (fifo_empty) begin
      if (pipe_req) grant = GNT_PIPE;
    end else if (!pipe_req) begin
      grant = GNT_MC;
    end else if (starve_cnt_q < LIMIT) begin
      grant = GNT_PIPE;
    end else begin
      // Head has starved long enough: steal the port and hold the pipeline.
      grant     = GNT_MC;
      stall_req = rst_n;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (!fifo_empty && grant == GNT_PIPE && starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_rd_addr;
        rf_wdata_d = pipe_wdata;
      end
      GNT_MC: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head.rd;
        rf_wdata_d = head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised plus directed bench: a queue-based model of the arbitration rules
// predicts every register-file write; a monitor checks them as they appear.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_reg_write_en, wb_mem_to_reg;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data_memory, wb_alu_result;
  logic        mc_valid;
  logic [4:0]  mc_rd_addr;
  logic [31:0] mc_data;
  logic        mc_ready, stall_req, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_reg_write_en (wb_reg_write_en),
    .wb_mem_to_reg   (wb_mem_to_reg),
    .wb_rd_addr      (wb_rd_addr),
    .wb_data_memory  (wb_data_memory),
    .wb_alu_result   (wb_alu_result),
    .mc_valid        (mc_valid),
    .mc_rd_addr      (mc_rd_addr),
    .mc_data         (mc_data),
    .mc_ready        (mc_ready),
    .stall_req       (stall_req),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } mc_t;

  exp_t exp_q[$];
  mc_t  model_fifo[$];
  int   model_starve = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus the bench wants to present this cycle
  logic        rst_v = 1'b0;
  logic        p_we = 0, p_m2r = 0;
  logic [4:0]  p_rd = 0, m_rd = 0;
  logic [31:0] p_dm = 0, p_alu = 0, m_data = 0;
  logic        m_v = 0;

  // Model predictions for the cycle just evaluated
  logic exp_stall, exp_ready;
  logic dut_stall_seen;
  logic prev_rst_low = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the write port fires.
  always @(posedge clk) begin
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write cyc=%0d actual rd=%0d data=0x%0h required none",
                 cyc, rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
        chk("wr_data", rf_wdata, e.data);
      end
    end
  end

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step();
    logic pipe_req, head_lost;
    logic [31:0] pdata;
    int grant; // 0 none, 1 pipe, 2 mc
    @(negedge clk);
    rst_n           = rst_v;
    wb_reg_write_en = p_we;
    wb_mem_to_reg   = p_m2r;
    wb_rd_addr      = p_rd;
    wb_data_memory  = p_dm;
    wb_alu_result   = p_alu;
    mc_valid        = m_v;
    mc_rd_addr      = m_rd;
    mc_data         = m_data;
    #1;
    if (prev_rst_low && rst_v) begin
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
    end
    pipe_req  = p_we && (p_rd != 0);
    pdata     = p_m2r ? p_dm : p_alu;
    exp_ready = !rst_v || (model_fifo.size() < DEPTH);
    exp_stall = 1'b0;
    head_lost = 1'b0;
    if (model_fifo.size() == 0) grant = pipe_req ? 1 : 0;
    else if (!pipe_req) grant = 2;
    else if (model_starve < STARVE_LIMIT) begin
      grant = 1;
      head_lost = 1'b1;
    end else begin
      grant = 2;
      exp_stall = rst_v;
    end
    chk("mc_ready", {31'd0, mc_ready}, {31'd0, exp_ready});
    chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
    dut_stall_seen = stall_req;
    if (!rst_v) begin
      model_fifo.delete();
      model_starve = 0;
    end else begin
      if (grant == 1) exp_q.push_back('{rd: p_rd, data: pdata, cyc: cyc + 1});
      if (grant == 2) begin
        mc_t h;
        h = model_fifo.pop_front();
        exp_q.push_back('{rd: h.rd, data: h.data, cyc: cyc + 1});
        model_starve = 0;
      end
      if (head_lost && model_starve < STARVE_LIMIT) model_starve++;
      if (m_v && exp_ready && m_rd != 0) model_fifo.push_back('{rd: m_rd, data: m_data});
    end
    prev_rst_low = !rst_v;
  endtask

  function automatic bit mc_held();
    return m_v && !exp_ready;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (!exp_stall) p_we = 0;
      if (!mc_held()) m_v = 0;
      step();
    end
  endtask

  int stalls;
  int full_seen;

  initial begin
    rst_n = 0; wb_reg_write_en = 0; wb_mem_to_reg = 0; wb_rd_addr = 0;
    wb_data_memory = 0; wb_alu_result = 0; mc_valid = 0; mc_rd_addr = 0; mc_data = 0;
    exp_stall = 0; exp_ready = 1;

    // Reset, with traffic presented to prove it is ignored
    rst_v = 0; p_we = 1; p_rd = 4; p_alu = 32'h1111; m_v = 1; m_rd = 6; m_data = 32'h66;
    step(); step();
    rst_v = 1; p_we = 0; m_v = 0;
    idle(2);

    // Pipeline-only write from memory data
    p_we = 1; p_m2r = 1; p_rd = 5; p_dm = 32'hDEADBEEF; p_alu = 32'h12345678;
    step();
    idle(2);

    // x0 suppression on both sources
    p_we = 1; p_m2r = 0; p_rd = 0; p_alu = 32'hBAD0;
    step();
    p_we = 0; m_v = 1; m_rd = 0; m_data = 32'hBAD1;
    step();
    idle(3);

    // Idle-slot drain
    m_v = 1; m_rd = 7; m_data = 32'h42;
    step();
    idle(3);

    // Starvation: buffered rd 9 against back-to-back pipeline writes to rd 3
    m_v = 1; m_rd = 9; m_data = 32'h900;
    step();
    m_v = 0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      if (!exp_stall) begin
        p_we = 1; p_m2r = 0; p_rd = 3; p_alu = 32'h300 + i;
      end
      step();
      stalls += int'(dut_stall_seen);
    end
    chk("starve_stall_count", stalls, 1);
    idle(3);

    // Full FIFO under continuous pipeline traffic
    full_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (!exp_stall) begin
        p_we = 1; p_m2r = i[0]; p_rd = 5'(10 + i); p_dm = 32'hA000 + i; p_alu = 32'hB000 + i;
      end
      if (!mc_held()) begin
        m_v = 1; m_rd = 5'(20 + (i % 8)); m_data = 32'hC000 + i;
      end
      step();
      if (!exp_ready) full_seen++;
    end
    chk("full_observed", {31'd0, full_seen > 0}, 32'd1);
    idle(8);

    // Reset mid-operation with two entries queued
    p_we = 1; p_rd = 1; p_alu = 32'hD0;
    m_v = 1; m_rd = 17; m_data = 32'hE1;
    step();
    p_rd = 2; p_alu = 32'hD1; m_rd = 18; m_data = 32'hE2;
    step();
    chk("queued_before_reset", model_fifo.size(), 2);
    rst_v = 0; p_we = 0; m_v = 0;
    step();
    rst_v = 1;
    idle(6);

    // Randomised traffic honouring stall and ready handshakes
    for (int i = 0; i < 3000; i++) begin
      if (!exp_stall) begin
        p_we  = ($urandom_range(0, 3) != 0);
        p_m2r = 1'($urandom_range(0, 1));
        p_rd  = 5'($urandom_range(0, 31));
        p_dm  = $urandom;
        p_alu = $urandom;
      end
      if (!mc_held()) begin
        m_v    = ($urandom_range(0, 2) == 0);
        m_rd   = 5'($urandom_range(0, 31));
        m_data = $urandom;
      end
      rst_v = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_v = 1;
    idle(20);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback, taken from the MEM/WB stage outputs, and late results from multi-cycle execution units such as the divider. Multi-cycle results are buffered in a small holding FIFO. The pipeline has priority. A starvation counter forces a one-cycle pipeline freeze so that buffered results always drain. The block sits between MEM/WB and the register file, and its stall output feeds the hazard unit.

## Interface

Parameters:
- `DEPTH`, default 2: holding FIFO entries; power of two, at least 2.
- `STARVE_LIMIT`, default 4: cycles a non-empty FIFO head may lose arbitration before a stall is forced; at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wb_reg_write_en`  in  1  write enable from MEM/WB.
- `wb_mem_to_reg`  in  1  1 selects `wb_data_memory`; 0 selects `wb_alu_result`.
- `wb_rd_addr`  in  5  destination register from MEM/WB.
- `wb_data_memory`  in  32  load data.
- `wb_alu_result`  in  32  ALU result.
- `mc_valid`  in  1  multi-cycle unit has a result.
- `mc_rd_addr`  in  5  destination of the multi-cycle result.
- `mc_data`  in  32  multi-cycle result value.
- `mc_ready`  out  1  FIFO can accept; equals `!full`.
- `stall_req`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.

## Operation

- **Pipeline request:** `pipe_req = wb_reg_write_en && wb_rd_addr != 0`.
- **Pipeline write data:** `wb_mem_to_reg ? wb_data_memory : wb_alu_result`.
- **FIFO push:** on `mc_valid && mc_ready` with `mc_rd_addr != 0`.
- **x0 results:** handshake completes (`mc_valid && mc_ready`) with `mc_rd_addr == 0`; the result is discarded and not stored.
- **Grant, evaluated each cycle:**
  - FIFO empty: GNT_PIPE if `pipe_req`, else GNT_NONE.
  - FIFO non-empty, `!pipe_req`: GNT_MC, head popped.
  - FIFO non-empty, `pipe_req`, `starve_cnt < STARVE_LIMIT`: GNT_PIPE.
  - FIFO non-empty, `pipe_req`, `starve_cnt == STARVE_LIMIT`: GNT_MC with `stall_req = 1`. The pipeline instruction stays held in MEM/WB and is re-presented next cycle.
- **Starvation counter:**
  - 0 on reset and on every pop.
  - +1 each cycle the FIFO is non-empty and the grant is GNT_PIPE.
  - Saturates at `STARVE_LIMIT`.
- **WAW ordering:** the decode scoreboard guarantees that no pipeline instruction targets an rd with an outstanding multi-cycle result. The arbiter performs no rd comparison.
- **Reset mid-operation:** FIFO contents discarded; pointers, count and `starve_cnt` cleared.

## Timing

- **Output reset values:** `rf_we`, `rf_waddr` and `rf_wdata` reset to 0. `stall_req` is 0 and `mc_ready` is 1 during and after reset.
- **Write-port latency:** `rf_*` are registered, one cycle after the grant. GNT_NONE yields `rf_we = 0` next cycle; `rf_waddr` and `rf_wdata` hold their last values.
- **`stall_req`:** combinational from registered state and the current `wb_*` inputs, with no cycle delay. It is high only in the cycle the MC grant overrides a pipeline request.
- **`mc_ready`:** derived from the registered count, so it is a registered value.
  - Full at the start of a cycle gives `mc_ready = 0`, even if a pop occurs that cycle; there is no bypass.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- **No empty-FIFO bypass:** a push into an empty FIFO cannot be granted that cycle. The earliest write is `rf_we` two cycles after the push.
- **Pointer wrap-around:** pointers are `log2(DEPTH)` bits and wrap naturally. The count is `log2(DEPTH)+1` bits.

## Structure

- **Shared package `defs`:**
  - `XLEN = 32` and `REG_ADDR_W = 5`.
  - Grant enum: GNT_NONE, GNT_PIPE, GNT_MC.
- **Sub-module `wb_hold_fifo`:** synchronous FIFO, parameterised by `DEPTH`, holding `{rd, data}`, with push, pop, full, empty and head ports.
- **Top level:** grant logic, starvation counter and output registers.

## Test plan

- **Pipeline-only write:** `wb_reg_write_en = 1`, rd=5, `wb_mem_to_reg = 1`, memory data 0xDEADBEEF → next cycle `rf_we = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`; `stall_req` stays 0.
- **x0 suppression:** rd=0 from the pipeline, then `mc_valid` with rd=0 → `rf_we` never asserts; `mc_ready` stays 1; FIFO stays empty.
- **Idle-slot drain:** MC result rd=7, value 0x42 pushed while the pipeline is idle → `rf_we`, rd 7, 0x42 two cycles after the push.
- **Starvation:** `STARVE_LIMIT = 4`; FIFO holds rd=9; continuous pipeline writes to rd=3 → four GNT_PIPE writes, then `stall_req = 1` for exactly one cycle; rd=9 is written; the held rd=3 instruction is written the cycle after.
- **Full FIFO:** fill `DEPTH = 2` under continuous pipeline traffic → `mc_ready = 0`; a third `mc_valid` is held until the cycle after a pop; no result is lost or duplicated.
- **Reset mid-operation:** assert `rst_n = 0` with 2 entries queued → next edge: all `rf_*` are 0, `mc_ready = 1`, and the queued entries are never written.
